pps_accum16: RTL and testbench

- Downstream consumer of the 16-bit partial-square generators (pps16_* family) in the M2 squarer datapath.
- Accepts a stream of NPP partial squares, least-significant first, over a valid/ready handshake.
- Weights partial square i by 2^(SHIFT*i), sign-extends and accumulates it into an ACC_W-bit result.
- Presents the full square on a held-until-taken valid/ready output.

---
 rtl/pps_accum16_pkg.sv | 26 ++
 rtl/pps_shift_ext.sv | 33 +++
 rtl/pps_accum16.sv | 118 +++++++++++
 tb/tb_pps_accum16.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pps_accum16_pkg.sv
// pps_accum16_pkg
//   Shared definitions for the partial-square accumulator and the pps16_*
//   generators that feed it: default datapath geometry and the controller
//   state encoding.
package pps_accum16_pkg;

  // Default geometry: 16-bit operand, radix-4 recoding -> 8 partial squares,
  // each weighted 2 bits above the previous one.
  localparam int PP_W_DEF  = 16;
  localparam int NPP_DEF   = 8;
  localparam int SHIFT_DEF = 2;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the partial-square index counter; never narrower than one bit
  // so the NPP==1 corner still has a legal vector.
  function automatic int idx_width(input int npp);
    return (npp > 1) ? $clog2(npp) : 1;
  endfunction

endpackage

// File: rtl/pps_shift_ext.sv
// pps_shift_ext
//   Combinational weighting of one partial square: sign-extends pp to ACC_W
//   bits and shifts it left by SHIFT*idx through a log-depth mux shifter.
// Ports:
//   pp   in  PP_W   two's-complement partial square
//   idx  in  IDX_W  position of pp within the operand
//   ext  out ACC_W  sext(pp) << (SHIFT*idx), truncated to ACC_W bits
module pps_shift_ext
  import pps_accum16_pkg::*;
#(
  parameter int PP_W  = PP_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int IDX_W = 3
) (
  input  logic [PP_W-1:0]  pp,
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] ext
);

  logic [IDX_W:0][ACC_W-1:0] stage;

  assign stage[0] = ACC_W'($signed(pp));

  // Stage b shifts by SHIFT*2^b when idx bit b is set, so the total shift
  // is SHIFT*idx after IDX_W stages.
  for (genvar b = 0; b < IDX_W; b++) begin : g_stage
    assign stage[b+1] = idx[b] ? (stage[b] << (SHIFT * (1 << b))) : stage[b];
  end

  assign ext = stage[IDX_W];

endmodule

// File: rtl/pps_accum16.sv
// pps_accum16
//   Accumulates a stream of NPP partial squares (least-significant first)
//   into the full square and presents it on a held-until-taken output.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous abort, discards the partial sum
//   pp         in   PP_W partial square
//   pp_valid   in   pp is valid this cycle
//   pp_ready   out  block can accept pp this cycle
//   res        out  ACC_W accumulated square
//   res_valid  out  res is valid
//   res_ready  in   consumer takes res this cycle
//   busy       out  operand in progress or result waiting
module pps_accum16
  import pps_accum16_pkg::*;
#(
  parameter int PP_W  = PP_W_DEF,
  parameter int NPP   = NPP_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [PP_W-1:0]  pp,
  input  logic             pp_valid,
  output logic             pp_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int IDX_W = idx_width(NPP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPP - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] weighted;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             xfer;
  logic             last;

  pps_shift_ext #(
    .PP_W  (PP_W),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .IDX_W (IDX_W)
  ) u_shift_ext (
    .pp  (pp),
    .idx (idx),
    .ext (weighted)
  );

  // A new operand always starts from zero rather than whatever acc still
  // holds from the previous one.
  assign base = (state == ST_IDLE) ? '0 : acc;
  assign sum  = base + weighted;
  assign xfer = pp_valid && pp_ready;
  assign last = (idx == IDX_LAST);

  // Handshake outputs decode the state register only, so pp_ready never
  // depends on pp_valid and res_valid never depends on res_ready.
  always_comb begin
    next_state = state;
    pp_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        pp_ready = 1'b1;
        if (xfer) next_state = last ? ST_DONE : ST_ACC;
      end
      ST_ACC: begin
        pp_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last) next_state = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
        if (res_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (clr) next_state = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Index counter, running sum and result register. The final transfer
  // loads res with the complete sum on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
      res <= '0;
    end else if (clr) begin
      idx <= '0;
      acc <= '0;
    end else if (xfer) begin
      acc <= sum;
      if (last) begin
        idx <= '0;
        res <= sum;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pps_accum16.sv
// tb_pps_accum16
//   Directed and randomized checks of pps_accum16 against an arithmetic
//   reference: square = sum over i of signed(pp_i) * 4^i, modulo 2^32.
module tb_pps_accum16;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [15:0] pp;
  logic        pp_valid;
  logic        pp_ready;
  logic [31:0] res;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] op [8];
  logic [31:0] held;

  pps_accum16 dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .pp        (pp),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference square of the operand currently held in op[].
  function automatic logic [31:0] refSquare();
    longint s = 0;
    for (int i = 0; i < 8; i++)
      s += longint'($signed(op[i])) * (longint'(1) << (2 * i));
    return s[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one partial square and hold it until it has been accepted.
  task automatic sendPp(input logic [15:0] v);
    int n = 0;
    pp       = v;
    pp_valid = 1'b1;
    while (!pp_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("pp_ready_timeout", {31'd0, pp_ready}, 32'd1);
    tick();
    pp_valid = 1'b0;
  endtask

  // Send the first 'count' entries of op[], inserting gapLen idle cycles
  // after entry gapAfter.
  task automatic applyStimulus(input int count, input int gapAfter,
                               input int gapLen);
    for (int i = 0; i < count; i++) begin
      if (i == 7) checkOutput("no_early_valid", {31'd0, res_valid}, 32'd0);
      sendPp(op[i]);
      if (i == gapAfter) repeat (gapLen) tick();
    end
  endtask

  // Hold off the consumer for holdCycles, then take the result.
  task automatic takeResult(input int holdCycles, input logic [31:0] exp,
                            input string tag);
    checkOutput({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput(tag, res, exp);
    for (int c = 0; c < holdCycles; c++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
      checkOutput({tag, "_hold_res"}, res, exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_taken_valid"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_taken_res"}, res, exp);
  endtask

  task automatic setOp(input logic [15:0] first, input logic [15:0] rest,
                       input logic [15:0] top);
    op[0] = first;
    for (int i = 1; i < 7; i++) op[i] = rest;
    op[7] = top;
  endtask

  task automatic randomOp();
    for (int i = 0; i < 8; i++) op[i] = 16'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    pp        = '0;
    pp_valid  = 1'b0;
    res_ready = 1'b0;

    // Reset values.
    #12;
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_res", res, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_pp_ready", {31'd0, pp_ready}, 32'd1);

    // Single LSB; result valid right after the 8th transfer edge.
    setOp(16'h0001, 16'h0000, 16'h0000);
    applyStimulus(8, -1, 0);
    checkOutput("lsb_pp_ready", {31'd0, pp_ready}, 32'd0);
    checkOutput("lsb_busy", {31'd0, busy}, 32'd1);
    takeResult(0, 32'h00000001, "lsb");
    checkOutput("lsb_idle_busy", {31'd0, busy}, 32'd0);

    // Top weight.
    setOp(16'h0000, 16'h0000, 16'h0001);
    applyStimulus(8, -1, 0);
    takeResult(0, 32'h00004000, "top");

    // Sign extension.
    setOp(16'hFFFF, 16'hFFFF, 16'hFFFF);
    applyStimulus(8, -1, 0);
    takeResult(0, 32'hFFFFAAAB, "neg");

    // Max positive.
    setOp(16'h7FFF, 16'h7FFF, 16'h7FFF);
    applyStimulus(8, -1, 0);
    takeResult(0, 32'h2AAA2AAB, "maxpos");

    // Gap after pp2, backpressure with pp_valid offered during DONE.
    randomOp();
    applyStimulus(8, 2, 3);
    held = refSquare();
    pp       = 16'($urandom);
    pp_valid = 1'b1;
    takeResult(5, held, "bp");
    // Back-to-back second operand starts the cycle after the handoff.
    setOp(16'h0001, 16'h0000, 16'h0000);
    applyStimulus(8, -1, 0);
    takeResult(0, 32'h00000001, "b2b");

    // Abort after pp3, with a competing transfer in the clr cycle.
    randomOp();
    applyStimulus(4, -1, 0);
    clr      = 1'b1;
    pp       = 16'h1234;
    pp_valid = 1'b1;
    tick();
    clr      = 1'b0;
    pp_valid = 1'b0;
    checkOutput("clr_busy", {31'd0, busy}, 32'd0);
    checkOutput("clr_pp_ready", {31'd0, pp_ready}, 32'd1);
    checkOutput("clr_res_kept", res, 32'h00000001);
    setOp(16'h0005, 16'h0000, 16'h0000);
    applyStimulus(8, -1, 0);
    takeResult(0, 32'h00000005, "clr_next");

    // Asynchronous reset after pp5.
    randomOp();
    applyStimulus(6, -1, 0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_res", res, 32'd0);
    checkOutput("arst_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Randomized operands with random gaps and consumer delays.
    for (int t = 0; t < 12; t++) begin
      randomOp();
      applyStimulus(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      takeResult(int'($urandom_range(0, 3)), refSquare(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
